// File: rtl/mem_req_arbiter.sv
// Arbiter that lets the instruction-fetch and load/store requesters share one sram-like port.
// An in-order ID FIFO records who owns each outstanding transaction so responses are routed back.
module mem_req_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  owner_e          fifo_owner   [MAX_OUTSTANDING];
  logic            fifo_discard [MAX_OUTSTANDING];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            lock;
  owner_e          lock_owner;

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            room;
  logic            grant_valid;
  owner_e          grant_owner;
  owner_e          head_owner;
  logic            head_discard;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CW'(MAX_OUTSTANDING));
  assign pop          = mem_data_ok & ~fifo_empty;
  // A full FIFO still has room when its head retires in the same cycle.
  assign room         = ~fifo_full | pop;
  assign head_owner   = fifo_owner[rd_ptr];
  assign head_discard = fifo_discard[rd_ptr];

  // A stalled request keeps its grant so the shared port never sees it withdrawn or switched.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_DATA;
    if (lock) begin
      grant_valid = 1'b1;
      grant_owner = lock_owner;
    end else if (room) begin
      if (data_req) begin
        grant_valid = 1'b1;
        grant_owner = OWN_DATA;
      end else if (inst_req && !flush) begin
        grant_valid = 1'b1;
        grant_owner = OWN_INST;
      end
    end
  end

  always_comb begin
    mem_req   = grant_valid;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_valid) begin
      if (grant_owner == OWN_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = 2'd2;
        mem_addr  = inst_addr;
      end
    end
  end

  assign push         = grant_valid & mem_addr_ok;
  assign inst_addr_ok = push & (grant_owner == OWN_INST);
  assign data_addr_ok = push & (grant_owner == OWN_DATA);

  // A flush in the pop cycle also suppresses the head's response.
  assign data_data_ok = pop & (head_owner == OWN_DATA);
  assign inst_data_ok = pop & (head_owner == OWN_INST) & ~head_discard & ~flush;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign busy         = ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      lock       <= 1'b0;
      lock_owner <= OWN_INST;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_owner[i]   <= OWN_INST;
        fifo_discard[i] <= 1'b0;
      end
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
          if (fifo_owner[i] == OWN_INST) begin
            fifo_discard[i] <= 1'b1;
          end
        end
      end
      if (push) begin
        fifo_owner[wr_ptr]   <= grant_owner;
        fifo_discard[wr_ptr] <= (grant_owner == OWN_INST) & flush;
        wr_ptr               <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (grant_valid && !mem_addr_ok) begin
        lock       <= 1'b1;
        lock_owner <= grant_owner;
      end else if (mem_addr_ok) begin
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_mem_req_arbiter;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        flush;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of outstanding transactions in issue order.
  typedef struct {
    bit is_data;
    bit disc;
  } txn_t;
  txn_t mq[$];
  bit          m_lock, m_lock_data;
  bit          e_pop, e_room, e_gv, e_gd, e_iok, e_dok;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic        e_wr;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_lock = 0;
      m_lock_data = 0;
      chk("m_busy_rst", busy, 0);
    end else begin
      e_pop  = mem_data_ok && (mq.size() > 0);
      e_room = (mq.size() < MAXO) || e_pop;
      e_gv = 0;
      e_gd = 0;
      if (m_lock) begin
        e_gv = 1; e_gd = m_lock_data;
      end else if (e_room && data_req) begin
        e_gv = 1; e_gd = 1;
      end else if (e_room && inst_req && !flush) begin
        e_gv = 1; e_gd = 0;
      end
      e_wr = 0; e_size = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
      if (e_gv && e_gd) begin
        e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb;
        e_addr = data_addr; e_wdata = data_wdata;
      end else if (e_gv) begin
        e_size = 2; e_addr = inst_addr;
      end
      e_dok = e_pop ? mq[0].is_data : 1'b0;
      e_iok = e_pop ? (!mq[0].is_data && !mq[0].disc && !flush) : 1'b0;

      chk("m_mem_req", mem_req, e_gv);
      chk("m_mem_wr", mem_wr, e_wr);
      chk("m_mem_size", mem_size, e_size);
      chk("m_mem_wstrb", mem_wstrb, e_wstrb);
      chk("m_mem_addr", mem_addr, e_addr);
      chk("m_mem_wdata", mem_wdata, e_wdata);
      chk("m_inst_addr_ok", inst_addr_ok, e_gv && !e_gd && mem_addr_ok);
      chk("m_data_addr_ok", data_addr_ok, e_gv && e_gd && mem_addr_ok);
      chk("m_inst_data_ok", inst_data_ok, e_iok);
      chk("m_data_data_ok", data_data_ok, e_dok);
      chk("m_busy", busy, mq.size() != 0);
      if (e_iok) chk("m_inst_rdata", inst_rdata, mem_rdata);
      if (e_dok) chk("m_data_rdata", data_rdata, mem_rdata);

      if (e_pop) void'(mq.pop_front());
      if (flush) foreach (mq[i]) if (!mq[i].is_data) mq[i].disc = 1;
      if (e_gv && mem_addr_ok) mq.push_back('{is_data: e_gd, disc: !e_gd && flush});
      if (e_gv && !mem_addr_ok) begin
        m_lock = 1; m_lock_data = e_gd;
      end else if (mem_addr_ok) begin
        m_lock = 0;
      end
    end
  end

  task automatic idle();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    flush = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a);
    data_req = 1; data_wr = 0; data_size = 2; data_wstrb = 0; data_addr = a; data_wdata = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sample();
    chk("reset_busy", busy, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_addr", mem_addr, 0);

    // Concurrent requests: data first, then inst
    tick();
    inst_req = 1; inst_addr = 32'h1C00_0000; load(32'h0000_1000); mem_addr_ok = 1;
    sample();
    chk("conc_c0_addr", mem_addr, 32'h0000_1000);
    chk("conc_c0_data_aok", data_addr_ok, 1);
    chk("conc_c0_inst_aok", inst_addr_ok, 0);
    tick(); data_req = 0;
    sample();
    chk("conc_c1_addr", mem_addr, 32'h1C00_0000);
    chk("conc_c1_inst_aok", inst_addr_ok, 1);
    tick(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_0000;
    sample();
    chk("conc_r0_dok", data_data_ok, 1);
    chk("conc_r0_rdata", data_rdata, 32'hAAAA_0000);
    chk("conc_r0_iok", inst_data_ok, 0);
    tick(); mem_rdata = 32'hBBBB_0000;
    sample();
    chk("conc_r1_iok", inst_data_ok, 1);
    chk("conc_r1_rdata", inst_rdata, 32'hBBBB_0000);
    tick(); idle();
    sample();
    chk("conc_done_busy", busy, 0);

    // Lock: stalled inst keeps the port; data store waits
    tick(); inst_req = 1; inst_addr = 32'h1C00_0000;
    sample();
    chk("lock_c0_addr", mem_addr, 32'h1C00_0000);
    tick();
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_addr = 32'h0000_2000; data_wdata = 32'hDEAD_BEEF;
    sample();
    chk("lock_c1_addr", mem_addr, 32'h1C00_0000);
    chk("lock_c1_wdata", mem_wdata, 0);
    tick();
    sample();
    chk("lock_c2_addr", mem_addr, 32'h1C00_0000);
    tick(); mem_addr_ok = 1;
    sample();
    chk("lock_c3_inst_aok", inst_addr_ok, 1);
    chk("lock_c3_data_aok", data_addr_ok, 0);
    tick(); inst_req = 0;
    sample();
    chk("lock_c4_addr", mem_addr, 32'h0000_2000);
    chk("lock_c4_data_aok", data_addr_ok, 1);
    tick(); data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11;
    sample();
    chk("lock_r0_iok", inst_data_ok, 1);
    tick(); mem_rdata = 32'h22;
    sample();
    chk("lock_r1_dok", data_data_ok, 1);
    tick(); idle();

    // Full FIFO: third request waits for a pop
    inst_req = 1; inst_addr = 32'h1C00_0010; mem_addr_ok = 1;
    sample();
    tick(); inst_addr = 32'h1C00_0014;
    sample();
    tick(); inst_addr = 32'h1C00_0018;
    sample();
    chk("full_mem_req", mem_req, 0);
    chk("full_busy", busy, 1);
    tick(); mem_data_ok = 1; mem_rdata = 32'h33;
    sample();
    chk("full_pop_req", mem_req, 1);
    chk("full_pop_aok", inst_addr_ok, 1);
    chk("full_pop_iok", inst_data_ok, 1);
    tick(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    sample();
    chk("full_after_busy", busy, 1);
    tick(); mem_data_ok = 1; mem_rdata = 32'h34;
    sample();
    tick(); mem_rdata = 32'h35;
    sample();
    chk("full_last_iok", inst_data_ok, 1);
    tick(); idle();
    sample();
    chk("full_done_busy", busy, 0);

    // Flush discards pending inst responses; data still delivered
    tick(); inst_req = 1; inst_addr = 32'h1C00_0020; mem_addr_ok = 1;
    sample();
    tick(); inst_addr = 32'h1C00_0024;
    sample();
    tick(); inst_req = 0; mem_addr_ok = 0; flush = 1;
    sample();
    tick(); flush = 0; mem_data_ok = 1; mem_rdata = 32'h44;
    sample();
    chk("flush_r0_iok", inst_data_ok, 0);
    tick(); mem_rdata = 32'h55; load(32'h0000_3000); mem_addr_ok = 1;
    sample();
    chk("flush_r1_iok", inst_data_ok, 0);
    chk("flush_data_aok", data_addr_ok, 1);
    tick(); data_req = 0; mem_addr_ok = 0; mem_rdata = 32'h66;
    sample();
    chk("flush_data_dok", data_data_ok, 1);
    chk("flush_data_rdata", data_rdata, 32'h66);
    tick(); idle();
    // Flush in the same cycle the inst head returns; also blocks a new inst grant
    inst_req = 1; inst_addr = 32'h1C00_0030; mem_addr_ok = 1;
    sample();
    tick(); inst_addr = 32'h1C00_0034; flush = 1; mem_data_ok = 1; mem_rdata = 32'h77;
    sample();
    chk("flushpop_iok", inst_data_ok, 0);
    chk("flushpop_req", mem_req, 0);
    tick(); idle();
    sample();
    chk("flushpop_busy", busy, 0);

    // Store path
    tick();
    data_req = 1; data_wr = 1; data_size = 0; data_wstrb = 4'b0100;
    data_addr = 32'h0000_4002; data_wdata = 32'h00AB_0000; mem_addr_ok = 1;
    sample();
    chk("store_wr", mem_wr, 1);
    chk("store_size", mem_size, 0);
    chk("store_wstrb", mem_wstrb, 4'b0100);
    chk("store_wdata", mem_wdata, 32'h00AB_0000);
    chk("store_addr", mem_addr, 32'h0000_4002);
    tick(); idle(); mem_data_ok = 1;
    sample();
    chk("store_dok", data_data_ok, 1);
    chk("store_iok", inst_data_ok, 0);
    tick(); idle();

    // Async reset with two outstanding
    inst_req = 1; inst_addr = 32'h1C00_0040; mem_addr_ok = 1;
    sample();
    tick(); inst_addr = 32'h1C00_0044;
    sample();
    tick(); idle(); rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mem_req", mem_req, 0);
    tick(); rst = 0; mem_data_ok = 1; mem_rdata = 32'h99;
    sample();
    chk("stray_iok", inst_data_ok, 0);
    chk("stray_dok", data_data_ok, 0);
    chk("stray_busy", busy, 0);
    tick(); idle();
    sample();
    chk("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one sram-like data-memory port between the instruction-fetch requester (IF) and the load/store requester (EX issue, MEM response).
- Arbitrates requests and tracks outstanding transactions in an in-order ID FIFO.
- Routes each returning data_ok/rdata back to the owning requester.
- Discards in-flight instruction responses after a pipeline flush (ertn/exception), so MEM_ready_go and IF see only their own responses.

Parameters:
MAX_OUTSTANDING, 2, depth of the outstanding-transaction FIFO (legal 1..4). No new request is accepted while the FIFO is full.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  IF request valid, held until inst_addr_ok
inst_addr  in  32  IF request address (always a read, size 2)
inst_addr_ok  out  1  IF request accepted this cycle
inst_data_ok  out  1  IF response valid
inst_rdata  out  32  IF response data
data_req  in  1  load/store request valid, held until data_addr_ok
data_wr  in  1  1 = store
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  4  store byte enables
data_addr  in  32  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  load/store request accepted this cycle
data_data_ok  out  1  load/store response valid
data_rdata  out  32  load response data
flush  in  1  pipeline flush; discard all pending IF responses
mem_req  out  1  shared-port request
mem_wr  out  1  shared-port write
mem_size  out  2  shared-port size
mem_wstrb  out  4  shared-port byte enables
mem_addr  out  32  shared-port address
mem_wdata  out  32  shared-port write data
mem_addr_ok  in  1  shared-port request accepted
mem_data_ok  in  1  shared-port response valid (in order)
mem_rdata  in  32  shared-port response data
busy  out  1  FIFO non-empty

Behaviour:
- Reset (async):
  - FIFO empty; rd/wr pointers and count = 0; all discard bits 0.
  - lock = 0, lock_owner = 0.
  - All outputs deasserted; mem_* payload = 0 via muxing with no grant.
- Grant (combinational):
  - No grant if FIFO full, or if the count will still be full this cycle (no pop).
  - If lock = 1, grant lock_owner.
  - Otherwise data wins over inst when both request.
  - inst is not granted in a cycle with flush = 1 unless it is locked.
- mem_* mirrors the granted requester's fields. Inst grant drives wr = 0, size = 2, wstrb = 0, wdata = 0.
- mem_req = grant valid.
- inst_addr_ok = mem_addr_ok & grant_inst; data_addr_ok = mem_addr_ok & grant_data.
- Lock:
  - When mem_req = 1 and mem_addr_ok = 0, set lock = 1 and lock_owner = granted requester. The shared port never sees a request withdrawn or switched.
  - Clear lock on the mem_addr_ok cycle.
- Push: on mem_req & mem_addr_ok, push {owner, discard}. discard = 1 if owner = inst and flush = 1 in the same cycle.
- Pop: on mem_data_ok with FIFO non-empty, pop the head.
  - Owner = data: data_data_ok = 1, data_rdata = mem_rdata.
  - Owner = inst and discard = 0: inst_data_ok = 1, inst_rdata = mem_rdata.
  - discard = 1: no data_ok to anyone.
  - Zero added latency: data_ok is combinational from mem_data_ok.
- Simultaneous push and pop: count unchanged and both pointers advance. A full FIFO may accept a push in a cycle where it also pops.
- flush: sets discard on every valid inst entry, including the head being popped in the same cycle. That head's response is suppressed. Data entries are never discarded.
- mem_data_ok with FIFO empty: ignored, no state change.
- Pointers wrap modulo MAX_OUTSTANDING.
- busy = count != 0.
- Reset mid-transaction: all tracking is dropped. The shared-port slave is reset on the same reset.

Test Plan:
- Concurrent requests: inst_req = 1 (addr 0x1C000000) and data_req = 1 (load word, 0x00001000), mem_addr_ok = 1 -> cycle 0 grants data (mem_addr = 0x1000, data_addr_ok = 1), cycle 1 grants inst. Responses 0xAAAA0000, 0xBBBB0000 -> data_rdata = 0xAAAA0000, then inst_rdata = 0xBBBB0000.
- Lock: inst requests with mem_addr_ok = 0 for 3 cycles, data_req rises in cycle 1 -> mem_addr stays 0x1C000000 until accepted. Data is granted on the following cycle.
- Full FIFO (depth 2): two inst requests outstanding, third request -> mem_req = 0. In the cycle mem_data_ok = 1, the third request is accepted; busy stays 1 and count stays 2.
- Flush with pending inst: 2 inst outstanding, flush pulse -> the next two mem_data_ok produce no inst_data_ok. A following data load response reaches data_data_ok.
- Store path: data_wr = 1, size = 0, wstrb = 4'b0100, wdata = 0x00AB0000 -> mem_* fields match exactly and inst_data_ok never fires. Store data_ok is returned to the data requester.
- Async reset asserted with 2 outstanding -> busy = 0 immediately. A stray mem_data_ok afterward is ignored.
